// File: rtl/permutation_output_buffer_pkg.sv
// Shared widths and the buffered entry layout {seriesEnd, bot} for the permutation output buffer.
package permutation_output_buffer_pkg;

  localparam int unsigned PERMUTATIONS_PER_SERIES = 42;
  localparam int unsigned BOT_WIDTH               = 128;
  localparam int unsigned ENTRY_WIDTH             = BOT_WIDTH + 1;
  localparam int unsigned PERM_CNT_WIDTH          = 6;

  typedef struct packed {
    logic                 series_end;
    logic [BOT_WIDTH-1:0] bot;
  } entry_t;

endpackage

// File: rtl/permutation_output_fifo.sv
// Single-clock FWFT FIFO: one-cycle write-to-read visibility, then a registered output stage.
module permutation_output_fifo
  import permutation_output_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_en,
  input  entry_t              i_wr_data,
  input  logic                i_rd_ready,
  output entry_t              o_rd_data,
  output logic                o_rd_valid,
  output logic [DEPTH_LOG2:0] o_usedw,
  output logic [DEPTH_LOG2:0] o_usedw_next_c,
  output logic                o_full_c
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  entry_t                r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_wptr_vis;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [CNT_W-1:0]      r_count;
  entry_t                r_out_data;
  logic                  r_out_valid;

  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_mem_avail;
  logic                  w_load;
  logic [CNT_W-1:0]      w_count_next;

  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_push      = i_wr_en && !w_full;
  assign w_pop       = r_out_valid && i_rd_ready;
  // Entries become readable one edge after they are written (models RAM read latency).
  assign w_mem_avail = (r_rptr != r_wptr_vis);
  assign w_load      = (!r_out_valid || w_pop) && w_mem_avail;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Storage array: no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_wptr_vis  <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_wptr_vis <= r_wptr;
      r_count    <= w_count_next;
      if (w_push) begin
        r_wptr <= r_wptr + DEPTH_LOG2'(1);
      end
      if (w_load) begin
        r_out_data  <= r_mem[r_rptr];
        r_out_valid <= 1'b1;
        r_rptr      <= r_rptr + DEPTH_LOG2'(1);
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_rd_data      = r_out_data;
  assign o_rd_valid     = r_out_valid;
  assign o_usedw        = r_count;
  assign o_usedw_next_c = w_count_next;
  assign o_full_c       = w_full;

endmodule

// File: rtl/permutation_output_buffer.sv
// Buffers one generator lane's permuted bots, throttles it via slowDown and counts series.
// Optional permutation-count checking is enabled by defining PERMUTATION_COUNT_CHECK_EN.
module permutation_output_buffer
  import permutation_output_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2     = 7,
  parameter int unsigned SLOWDOWN_SLACK = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BOT_WIDTH-1:0] botIn,
  input  logic                 botInValid,
  input  logic                 seriesEndIn,
  output logic                 slowDown,
  output logic [BOT_WIDTH-1:0] botOut,
  output logic                 botOutValid,
  output logic                 botOutSeriesEnd,
  input  logic                 botOutReady,
  output logic [DEPTH_LOG2:0]  usedw,
  output logic [31:0]          seriesCompleted,
  output logic                 overflowError,
  output logic                 countError
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] SLOW_THRESH = CNT_W'(DEPTH - SLOWDOWN_SLACK);

  entry_t           w_wr_entry;
  entry_t           w_rd_entry;
  logic             w_rd_valid;
  logic [CNT_W-1:0] w_usedw_next;
  logic             w_full;
  logic             w_pop;

  logic             r_slow_down;
  logic [31:0]      r_series_completed;
  logic             r_overflow_error;

  assign w_wr_entry = '{series_end: seriesEndIn, bot: botIn};

  permutation_output_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_wr_en       (botInValid),
    .i_wr_data     (w_wr_entry),
    .i_rd_ready    (botOutReady),
    .o_rd_data     (w_rd_entry),
    .o_rd_valid    (w_rd_valid),
    .o_usedw       (usedw),
    .o_usedw_next_c(w_usedw_next),
    .o_full_c      (w_full)
  );

  assign w_pop = w_rd_valid && botOutReady;

  // Throttle, series counter and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slow_down        <= 1'b0;
      r_series_completed <= '0;
      r_overflow_error   <= 1'b0;
    end else begin
      r_slow_down <= (w_usedw_next > SLOW_THRESH);
      if (w_pop && w_rd_entry.series_end) begin
        r_series_completed <= r_series_completed + 32'd1;
      end
      if (botInValid && w_full) begin
        r_overflow_error <= 1'b1;
      end
    end
  end

`ifdef PERMUTATION_COUNT_CHECK_EN
  logic [PERM_CNT_WIDTH-1:0] r_perm_cnt;
  logic [PERM_CNT_WIDTH-1:0] w_perm_cnt_inc;
  logic                      r_count_error;
  logic                      w_accept;

  assign w_accept       = botInValid && !w_full;
  assign w_perm_cnt_inc = r_perm_cnt + PERM_CNT_WIDTH'(1);

  // Every accepted series must be exactly PERMUTATIONS_PER_SERIES writes long.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perm_cnt    <= '0;
      r_count_error <= 1'b0;
    end else begin
      if (w_accept) begin
        if (seriesEndIn) begin
          if (w_perm_cnt_inc != PERM_CNT_WIDTH'(PERMUTATIONS_PER_SERIES)) begin
            r_count_error <= 1'b1;
          end
          r_perm_cnt <= '0;
        end else begin
          if (r_perm_cnt == PERM_CNT_WIDTH'(PERMUTATIONS_PER_SERIES)) begin
            r_count_error <= 1'b1;
          end
          r_perm_cnt <= w_perm_cnt_inc;
        end
      end
      if (seriesEndIn && !botInValid) begin
        r_count_error <= 1'b1;
      end
    end
  end

  assign countError = r_count_error;
`else
  assign countError = 1'b0;
`endif

  assign slowDown        = r_slow_down;
  assign botOut          = w_rd_entry.bot;
  assign botOutValid     = w_rd_valid;
  assign botOutSeriesEnd = w_rd_entry.series_end;
  assign seriesCompleted = r_series_completed;
  assign overflowError   = r_overflow_error;

endmodule

// File: tb/tb_permutation_output_buffer.sv
// Directed bench for permutation_output_buffer with a latency-aware scoreboard of expected entries.
module tb_permutation_output_buffer;

  localparam int DEPTH_LOG2 = 7;
  localparam int DEPTH      = 128;
  localparam int THRESH     = 78;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] botIn = '0;
  logic         botInValid = 1'b0;
  logic         seriesEndIn = 1'b0;
  logic         slowDown;
  logic [127:0] botOut;
  logic         botOutValid;
  logic         botOutSeriesEnd;
  logic         botOutReady = 1'b0;
  logic [7:0]   usedw;
  logic [31:0]  seriesCompleted;
  logic         overflowError;
  logic         countError;

  permutation_output_buffer #(.DEPTH_LOG2(DEPTH_LOG2), .SLOWDOWN_SLACK(50)) dut (
    .clk            (clk),
    .rst            (rst),
    .botIn          (botIn),
    .botInValid     (botInValid),
    .seriesEndIn    (seriesEndIn),
    .slowDown       (slowDown),
    .botOut         (botOut),
    .botOutValid    (botOutValid),
    .botOutSeriesEnd(botOutSeriesEnd),
    .botOutReady    (botOutReady),
    .usedw          (usedw),
    .seriesCompleted(seriesCompleted),
    .overflowError  (overflowError),
    .countError     (countError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] bot;
    logic         se;
    int           wedge;
  } sb_t;

  sb_t         q[$];
  int          e = 0;
  int          m_used = 0;
  logic        m_slow = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_cerr = 1'b0;
  int unsigned m_series = 0;
  int          m_cnt = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          gen_k = 0;

  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_state();
    chk("usedw", 129'(usedw), 129'(m_used));
    chk("slowDown", 129'(slowDown), 129'(m_slow));
    chk("seriesCompleted", 129'(seriesCompleted), 129'(m_series));
    chk("overflowError", 129'(overflowError), 129'(m_ovf));
    chk("countError", 129'(countError), 129'(m_cerr));
  endtask

  // One clock: drive inputs, check presented entry, advance model, check registered state.
  task automatic step(input logic v, input logic [127:0] b, input logic se, input logic rdy);
    logic exp_v, push, pop;
    botInValid = v; botIn = b; seriesEndIn = se; botOutReady = rdy;
    @(negedge clk);
    exp_v = 1'b0;
    if (q.size() > 0) exp_v = (q[0].wedge <= e - 2);
    chk("botOutValid", 129'(botOutValid), 129'(exp_v));
    if (exp_v) chk("botOut", {botOutSeriesEnd, botOut}, {q[0].se, q[0].bot});
    pop  = exp_v && rdy;
    push = v && (m_used < DEPTH);
    if (v && m_used == DEPTH) m_ovf = 1'b1;
`ifdef PERMUTATION_COUNT_CHECK_EN
    if (push) begin
      if (se) begin
        if (m_cnt + 1 != 42) m_cerr = 1'b1;
        m_cnt = 0;
      end else begin
        if (m_cnt == 42) m_cerr = 1'b1;
        m_cnt = m_cnt + 1;
      end
    end
    if (se && !v) m_cerr = 1'b1;
`endif
    if (pop) begin
      if (q[0].se) m_series++;
      void'(q.pop_front());
    end
    if (push) q.push_back('{bot: b, se: se, wedge: e + 1});
    m_used = m_used + int'(push) - int'(pop);
    m_slow = (m_used > THRESH);
    @(posedge clk);
    e++;
    #1;
    chk_state();
  endtask

  // Write one generated bot; seriesEnd on every 42nd write since the last reset.
  task automatic gen_write(input logic rdy);
    logic [127:0] b;
    b = {$urandom(), $urandom(), $urandom(), 32'(gen_k)};
    step(1'b1, b, (gen_k % 42) == 41, rdy);
    gen_k++;
  endtask

  task automatic do_reset(input logic v, input logic rdy);
    rst = 1'b1; botInValid = v; botIn = 128'h1234; seriesEndIn = 1'b0; botOutReady = rdy;
    @(posedge clk);
    e++;
    #1;
    rst = 1'b0; botInValid = 1'b0; seriesEndIn = 1'b0; botOutReady = 1'b0;
    q.delete();
    m_used = 0; m_slow = 1'b0; m_ovf = 1'b0; m_cerr = 1'b0; m_series = 0; m_cnt = 0; gen_k = 0;
    chk("rst_botOutValid", 129'(botOutValid), 129'(0));
    chk("rst_botOutSeriesEnd", 129'(botOutSeriesEnd), 129'(0));
    chk_state();
  endtask

  initial begin
    // Single entry: visible after the second edge, then popped.
    do_reset(1'b0, 1'b0);
    step(1'b1, 128'hA5, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("single_bot", {botOutValid, botOut}, {1'b1, 128'hA5});
    step(1'b0, '0, 1'b0, 1'b1);
    chk("single_empty", 129'(usedw), 129'(0));

    // Three full series streamed with continuous ready.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 126; i++) gen_write(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);
    chk("three_series", 129'(seriesCompleted), 129'(3));
    chk("three_series_cerr", 129'(countError), 129'(0));

    // slowDown assertion, 42 further writes absorbed, release on drain.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 79; i++) gen_write(1'b0);
    chk("slow_at_79", 129'(slowDown), 129'(1));
    for (int i = 0; i < 42; i++) gen_write(1'b0);
    chk("slack_no_ovf", 129'(overflowError), 129'(0));
    for (int i = 0; i < 45; i++) step(1'b0, '0, 1'b0, 1'b1);
    chk("slow_released", 129'(slowDown), 129'(0));

    // Full FIFO: a write concurrent with a pop is still dropped.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) gen_write(1'b0);
    chk("full_usedw", 129'(usedw), 129'(DEPTH));
    gen_write(1'b1);
    chk("full_drop_usedw", 129'(usedw), 129'(DEPTH - 1));
    chk("full_drop_ovf", 129'(overflowError), 129'(1));
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b1);

`ifdef PERMUTATION_COUNT_CHECK_EN
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 128'(i), 1'b0, 1'b1);
    step(1'b1, 128'hEE, 1'b1, 1'b1);
    chk("short_series_cerr", 129'(countError), 129'(1));
    do_reset(1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("lone_se_cerr", 129'(countError), 129'(1));
`endif

    // Reset mid-operation with about 60 entries buffered and ready toggling.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 60; i++) gen_write(1'b0);
    for (int i = 0; i < 6; i++) gen_write(1'(i % 2));
    do_reset(1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
